// File: rtl/wb_spm_accel.sv
// wb_spm_accel: Wishbone-mapped serial shift-add multiplier that produces one product bit per clock.
// Signed mode multiplies the operand magnitudes, then negates the product.
module wb_spm_accel #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        busy_o,
  output logic        irq_o
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mc_q, mc_d, mp_q, mp_d, mcs_q, mcs_d, mag_c, mag_p;
  logic [PW-1:0] acc_q, acc_d, res;
  logic [WIDTH:0] sum;
  logic [63:0] res64;
  logic [31:0] plo_q, plo_d, phi_q, phi_d, dat_q, dat_d, mask, mc_w, mp_w, rdata;
  logic sgn_q, sgn_d, irq_en_q, irq_en_d, done_q, done_d, busy_q, busy_d;
  logic irq_q, irq_d, ack_q, ack_d, neg_q, neg_d;
  logic hit, req, wr, b0, go, w1c, fin, last, sm, sp;
  logic [2:0] off;
  logic unused_bits;
  assign unused_bits = ^wbs_adr_i[1:0];
  always_comb begin
    hit = wbs_adr_i[31:5] == BASE_ADDR[31:5];
    req = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
    wr = req & wbs_we_i;
    b0 = wr & wbs_sel_i[0];
    off = wbs_adr_i[4:2];
    mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    mc_w = (32'(mc_q) & ~mask) | (wbs_dat_i & mask);
    mp_w = (32'(mp_q) & ~mask) | (wbs_dat_i & mask);
    mc_d = (wr && off == 3'd0) ? mc_w[WIDTH-1:0] : mc_q;
    mp_d = (wr && off == 3'd1) ? mp_w[WIDTH-1:0] : mp_q;
    sgn_d = (b0 && off == 3'd2) ? wbs_dat_i[1] : sgn_q;
    irq_en_d = (b0 && off == 3'd2) ? wbs_dat_i[2] : irq_en_q;
    go = b0 && off == 3'd2 && wbs_dat_i[0] && state_q == IDLE;
    w1c = b0 && off == 3'd3 && wbs_dat_i[1];
    fin = state_q == FIN;
    last = cnt_q == CW'(WIDTH - 1);
    // SIGNED is taken from this same write so START|SIGNED in one access works
    sm = sgn_d & mc_q[WIDTH-1];
    sp = sgn_d & mp_q[WIDTH-1];
    mag_c = sm ? -mc_q : mc_q;
    mag_p = sp ? -mp_q : mp_q;
    sum = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcs_q} : '0);
    res = neg_q ? -acc_q : acc_q;
    res64 = 64'(res);
    state_d = go ? RUN : (state_q == RUN && last) ? FIN : fin ? IDLE : state_q;
    cnt_d = state_q == RUN ? cnt_q + CW'(1) : '0;
    acc_d = go ? {{WIDTH{1'b0}}, mag_p} : state_q == RUN ? {sum, acc_q[WIDTH-1:1]} : acc_q;
    mcs_d = go ? mag_c : mcs_q;
    neg_d = go ? sm ^ sp : neg_q;
    busy_d = state_d == RUN;
    plo_d = fin ? res64[31:0] : plo_q;
    phi_d = fin ? res64[63:32] : phi_q;
    done_d = fin | (done_q & ~go & ~w1c);
    irq_d = done_d & irq_en_d;
    rdata = off == 3'd0 ? 32'(mc_q) :
            off == 3'd1 ? 32'(mp_q) :
            off == 3'd2 ? {29'd0, irq_en_q, sgn_q, 1'b0} :
            off == 3'd3 ? {30'd0, done_q, busy_q} :
            off == 3'd4 ? plo_q :
            off == 3'd5 ? phi_q : 32'd0;
    ack_d = req;
    dat_d = req ? rdata : 32'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mc_q <= '0;
      mp_q <= '0;
      mcs_q <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      plo_q <= '0;
      phi_q <= '0;
      sgn_q <= 1'b0;
      irq_en_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      irq_q <= 1'b0;
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mc_q <= mc_d;
      mp_q <= mp_d;
      mcs_q <= mcs_d;
      acc_q <= acc_d;
      neg_q <= neg_d;
      plo_q <= plo_d;
      phi_q <= phi_d;
      sgn_q <= sgn_d;
      irq_en_q <= irq_en_d;
      done_q <= done_d;
      busy_q <= busy_d;
      irq_q <= irq_d;
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign busy_o = busy_q;
  assign irq_o = irq_q;
endmodule

// File: tb/tb_wb_spm_accel.sv
// tb_wb_spm_accel: scoreboard bench; reads push expected data, a monitor pops on each read ack.
// Two instances share the bus: A (WIDTH=32) at 0x3000_0000, B (WIDTH=8) at 0x3000_0100.
module tb_wb_spm_accel;
  localparam logic [31:0] BA = 32'h3000_0000;
  localparam logic [31:0] BB = 32'h3000_0100;
  logic clk = 1'b0, rst_n = 1'b0;
  logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0] sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic ack_a, ack_b, busy_a, busy_b, irq_a, irq_b;
  logic [31:0] dat_a, dat_b;
  int errors = 0, checks = 0;
  logic [31:0] exp_q[$];
  string name_q[$];
  logic prev_ack = 1'b0, irq_prev = 1'b0;
  int run_a = 0, last_a = 0, run_b = 0, last_b = 0, irq_rises = 0;
  always #5 clk = ~clk;
  wb_spm_accel #(.WIDTH(32), .BASE_ADDR(BA)) dut_a (
    .clk(clk), .rst_n(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_a),
    .wbs_dat_o(dat_a), .busy_o(busy_a), .irq_o(irq_a));
  wb_spm_accel #(.WIDTH(8), .BASE_ADDR(BB)) dut_b (
    .clk(clk), .rst_n(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_b),
    .wbs_dat_o(dat_b), .busy_o(busy_b), .irq_o(irq_b));
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  always @(negedge clk) begin
    if (ack_a | ack_b) begin
      checks++;
      if (prev_ack) begin
        errors++;
        $display("FAIL ack_width: ack high on two consecutive cycles");
      end
      if (!we) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL read_ack: unexpected read ack, data %h", ack_a ? dat_a : dat_b);
        end else chk(name_q.pop_front(), ack_a ? dat_a : dat_b, exp_q.pop_front());
      end
    end
    prev_ack = ack_a | ack_b;
    if (busy_a) run_a++;
    else if (run_a != 0) begin last_a = run_a; run_a = 0; end
    if (busy_b) run_b++;
    else if (run_b != 0) begin last_b = run_b; run_b = 0; end
    if (irq_a && !irq_prev) irq_rises++;
    irq_prev = irq_a;
  end
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    do begin @(posedge clk); #1; n++; end while (!(ack_a | ack_b) && n < 8);
    stb = 1'b0; cyc = 1'b0;
    if (!(ack_a | ack_b)) begin
      errors++;
      checks++;
      $display("FAIL bus_ack: no ack for adr %h, required ack", a);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    bus(1'b1, a, d, s);
  endtask
  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    bus(1'b0, a, 32'h0, 4'hF);
  endtask
  task automatic wait_idle(input bit b);
    int n = 0;
    while ((b ? busy_b : busy_a) && n < 200) begin @(posedge clk); #1; n++; end
    if (b ? busy_b : busy_a) begin
      errors++;
      checks++;
      $display("FAIL wait_idle: busy still 1 after 200 clk, required 0");
    end
  endtask
  initial begin
    int n, r0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_irq", {31'd0, irq_a}, 0);
    chk("rst_ack", {31'd0, ack_a | ack_b}, 0);
    chk("rst_dat", dat_a, 0);
    rst_n = 1'b1;
    rd("rst_mc", BA + 32'h00, 32'h0);
    rd("rst_stat", BA + 32'h0C, 32'h0);
    // unsigned full-scale
    wr(BA + 32'h00, 32'hFFFF_FFFF);
    wr(BA + 32'h04, 32'hFFFF_FFFF);
    wr(BA + 32'h08, 32'h1);
    wait_idle(0);
    @(posedge clk); #1;
    chk("u32_busy_len", last_a, 32);
    rd("u32_plo", BA + 32'h10, 32'h0000_0001);
    rd("u32_phi", BA + 32'h14, 32'hFFFF_FFFE);
    rd("u32_stat", BA + 32'h0C, 32'h2);
    // signed; DONE clears on START and PLO holds previous result while running
    wr(BA + 32'h00, 32'hFFFF_FFFD);
    wr(BA + 32'h04, 32'h7);
    wr(BA + 32'h08, 32'h3);
    rd("s_stat_run", BA + 32'h0C, 32'h1);
    rd("s_plo_hold", BA + 32'h10, 32'h0000_0001);
    wait_idle(0);
    @(posedge clk); #1;
    rd("s_plo", BA + 32'h10, 32'hFFFF_FFEB);
    rd("s_phi", BA + 32'h14, 32'hFFFF_FFFF);
    rd("s_ctrl", BA + 32'h08, 32'h2);
    wr(BA + 32'h00, 32'h8000_0000);
    wr(BA + 32'h04, 32'h8000_0000);
    wr(BA + 32'h08, 32'h3);
    wait_idle(0);
    @(posedge clk); #1;
    rd("smin_phi", BA + 32'h14, 32'h4000_0000);
    rd("smin_plo", BA + 32'h10, 32'h0);
    // WIDTH=8 instance
    wr(BB + 32'h00, 32'h1FF);
    rd("w8_mc_trunc", BB + 32'h00, 32'hFF);
    wr(BB + 32'h04, 32'hFF);
    wr(BB + 32'h08, 32'h1);
    wait_idle(1);
    @(posedge clk); #1;
    chk("w8_busy_len", last_b, 8);
    rd("w8_plo", BB + 32'h10, 32'h0000_FE01);
    rd("w8_phi", BB + 32'h14, 32'h0);
    wr(BB + 32'h00, 32'h80);
    wr(BB + 32'h04, 32'h80);
    wr(BB + 32'h08, 32'h3);
    wait_idle(1);
    @(posedge clk); #1;
    rd("w8_smin", BB + 32'h10, 32'h0000_4000);
    wr(BB + 32'h00, 32'hFF);
    wr(BB + 32'h04, 32'h01);
    wr(BB + 32'h08, 32'h3);
    wait_idle(1);
    @(posedge clk); #1;
    rd("w8_neg1", BB + 32'h10, 32'h0000_FFFF);
    // zero operand still runs full length
    wr(BA + 32'h00, 32'h0);
    wr(BA + 32'h04, 32'h12345);
    wr(BA + 32'h08, 32'h1);
    wait_idle(0);
    @(posedge clk); #1;
    chk("zero_busy_len", last_a, 32);
    rd("zero_plo", BA + 32'h10, 32'h0);
    rd("zero_phi", BA + 32'h14, 32'h0);
    // irq, ignored second START, operand write during run
    r0 = irq_rises;
    wr(BA + 32'h00, 32'h3);
    wr(BA + 32'h04, 32'h5);
    wr(BA + 32'h08, 32'h5);
    wr(BA + 32'h08, 32'h5);
    wr(BA + 32'h00, 32'h9);
    wait_idle(0);
    chk("irq_early", {31'd0, irq_a}, 0);
    @(posedge clk); #1;
    chk("irq_set", {31'd0, irq_a}, 1);
    chk("irq_busy_len", last_a, 32);
    rd("irq_stat", BA + 32'h0C, 32'h2);
    rd("irq_plo", BA + 32'h10, 32'd15);
    rd("irq_mc_new", BA + 32'h00, 32'h9);
    rd("irq_ctrl", BA + 32'h08, 32'h4);
    repeat (40) @(posedge clk);
    #1;
    chk("irq_one_done", irq_rises, r0 + 1);
    wr(BA + 32'h0C, 32'h2);
    chk("irq_clear", {31'd0, irq_a}, 0);
    rd("w1c_stat", BA + 32'h0C, 32'h0);
    // bus lanes, unmapped, miss, held strobe
    wr(BA + 32'h00, 32'h1122_3344);
    wr(BA + 32'h00, 32'hAABB_CCDD, 4'b0001);
    rd("sel_byte0", BA + 32'h00, 32'h1122_33DD);
    wr(BA + 32'h18, 32'hFFFF_FFFF);
    rd("unmap_18", BA + 32'h18, 32'h0);
    rd("unmap_1c", BA + 32'h1C, 32'h0);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BA + 32'h40; sel = 4'hF;
    n = 0;
    repeat (5) begin @(posedge clk); #1; if (ack_a | ack_b) n++; end
    stb = 1'b0; cyc = 1'b0;
    chk("miss_no_ack", n, 0);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BA; wdat = 32'h5555_AAAA; sel = 4'hF;
    repeat (5) @(posedge clk);
    #1;
    stb = 1'b0; cyc = 1'b0;
    rd("held_mc", BA + 32'h00, 32'h5555_AAAA);
    // reset mid-run
    wr(BA + 32'h00, 32'h6);
    wr(BA + 32'h04, 32'h7);
    wr(BA + 32'h08, 32'h5);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy_a}, 0);
    chk("mid_rst_irq", {31'd0, irq_a}, 0);
    chk("mid_rst_ack", {31'd0, ack_a | ack_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b0;
    n = 0;
    repeat (40) begin @(posedge clk); #1; if (ack_a | ack_b | busy_a | irq_a) n++; end
    chk("post_rst_quiet", n, 0);
    rd("post_rst_plo", BA + 32'h10, 32'h0);
    rd("post_rst_phi", BA + 32'h14, 32'h0);
    rd("post_rst_stat", BA + 32'h0C, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
